// File: rtl/mem_pkg.sv
// Shared types and constants for the pipeline memory-access stage.
// Imported by the stage controller and its data RAM.
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } op_t;

    localparam int MEM_LATENCY_DEF = 2;

    // Wide enough to hold the largest legal latency (8).
    localparam int CNT_W = 4;

    function automatic int log2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) width = i + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/mem_data_ram.sv
// Single-port synchronous data RAM, DEPTH x DATA_W.
// Writes and reads share one address; read data is registered.
module mem_data_ram
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = log2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // NOTE: the array has no reset so it maps onto block RAM; contents
    // survive a pipeline reset, which is the intended behaviour.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word loads/stores with configurable
// latency, branch resolution into a PC redirect, and write-back outputs.
module mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_flag_mem_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              reg_write_in,
    input  logic [4:0]        dest_reg,
    input  logic              branch_in,
    input  logic              zero_in,
    input  logic [DATA_W-1:0] branch_target,
    output logic              hold_upstream,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_reg,
    output logic              wb_en,
    output logic              stall_flag_mem_out,
    output logic              pc_src,
    output logic [DATA_W-1:0] pc_target,
    output logic              misalign_err
);

    localparam int IDX_W = log2(DEPTH);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_store_data;
    logic [4:0]         r_dest;
    op_t                r_op;
    logic               r_reg_write;

    logic [DATA_W-1:0]  r_wb_data;
    logic [4:0]         r_wb_reg;
    logic               r_wb_en;
    logic               r_stall_out;
    logic               r_pc_src;
    logic [DATA_W-1:0]  r_pc_target;
    logic               r_misalign_err;

    logic               w_accept;
    logic               w_mem_op;
    logic               w_misalign;
    logic               w_start_mem;
    logic               w_done;
    logic [IDX_W-1:0]   w_idx;
    logic               w_ram_we;
    logic [IDX_W-1:0]   w_ram_addr;
    logic [DATA_W-1:0]  w_ram_rdata;

    assign w_accept    = (r_state == IDLE) && !stall_flag_mem_in;
    assign w_mem_op    = mem_read || mem_write;
    assign w_misalign  = |alu_result[1:0];
    assign w_start_mem = w_accept && w_mem_op && !w_misalign;
    assign w_done      = (r_state == BUSY) && (r_cnt == CNT_W'(1));
    // Upper address bits are dropped, so word addresses wrap modulo DEPTH.
    assign w_idx       = alu_result[IDX_W+1:2];

    // NOTE: state and datapath registers use non-blocking assignments so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: each combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start_mem) w_state_next = BUSY;
            BUSY:    if (w_done)      w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        hold_upstream = (r_state == BUSY);
        w_ram_we      = w_done && (r_op == OP_STORE);
        // In IDLE the RAM pre-reads the incoming index so load data is
        // already registered by the completion edge, even at latency 1.
        w_ram_addr    = (r_state == BUSY) ? r_idx : w_idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_store_data <= '0;
            r_dest       <= '0;
            r_op         <= OP_NONE;
            r_reg_write  <= 1'b0;
        end else if (w_start_mem) begin
            r_cnt        <= CNT_W'(MEM_LATENCY);
            r_idx        <= w_idx;
            r_store_data <= store_data;
            r_dest       <= dest_reg;
            r_op         <= mem_write ? OP_STORE : OP_LOAD;
            r_reg_write  <= reg_write_in;
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_data      <= '0;
            r_wb_reg       <= '0;
            r_wb_en        <= 1'b0;
            r_stall_out    <= 1'b1;
            r_pc_src       <= 1'b0;
            r_pc_target    <= '0;
            r_misalign_err <= 1'b0;
        end else begin
            r_wb_en     <= 1'b0;
            r_pc_src    <= 1'b0;
            r_stall_out <= 1'b1;
            if (w_accept) begin
                r_pc_src    <= branch_in && zero_in;
                r_pc_target <= branch_target;
                // Misaligned memory ops retire here like ALU ops but never write back.
                if (!w_start_mem) begin
                    r_wb_data   <= alu_result;
                    r_wb_reg    <= dest_reg;
                    r_wb_en     <= reg_write_in && !w_mem_op;
                    r_stall_out <= 1'b0;
                end
                if (w_mem_op && w_misalign) begin
                    r_misalign_err <= 1'b1;
                end
            end
            if (w_done) begin
                if (r_op == OP_LOAD) begin
                    r_wb_data <= w_ram_rdata;
                end
                r_wb_reg    <= r_dest;
                r_wb_en     <= (r_op == OP_LOAD) && r_reg_write;
                r_stall_out <= 1'b0;
            end
        end
    end

    mem_data_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (r_store_data),
        .o_rdata (w_ram_rdata)
    );

    assign wb_data            = r_wb_data;
    assign wb_reg             = r_wb_reg;
    assign wb_en              = r_wb_en;
    assign stall_flag_mem_out = r_stall_out;
    assign pc_src             = r_pc_src;
    assign pc_target          = r_pc_target;
    assign misalign_err       = r_misalign_err;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected write-backs
// and redirects; a negedge monitor pops and compares them.
module tb_mem_stage;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int LAT    = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall_flag_mem_in;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write_in;
    logic [4:0]        dest_reg;
    logic              branch_in;
    logic              zero_in;
    logic [DATA_W-1:0] branch_target;
    logic              hold_upstream;
    logic [DATA_W-1:0] wb_data;
    logic [4:0]        wb_reg;
    logic              wb_en;
    logic              stall_flag_mem_out;
    logic              pc_src;
    logic [DATA_W-1:0] pc_target;
    logic              misalign_err;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        int          due;
    } wb_exp_t;

    typedef struct {
        logic [31:0] target;
        int          due;
    } pc_exp_t;

    wb_exp_t wb_q[$];
    pc_exp_t pc_q[$];
    int      cyc     = 0;
    int      n_check = 0;
    int      n_fail  = 0;

    mem_stage #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .stall_flag_mem_in  (stall_flag_mem_in),
        .alu_result         (alu_result),
        .store_data         (store_data),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .reg_write_in       (reg_write_in),
        .dest_reg           (dest_reg),
        .branch_in          (branch_in),
        .zero_in            (zero_in),
        .branch_target      (branch_target),
        .hold_upstream      (hold_upstream),
        .wb_data            (wb_data),
        .wb_reg             (wb_reg),
        .wb_en              (wb_en),
        .stall_flag_mem_out (stall_flag_mem_out),
        .pc_src             (pc_src),
        .pc_target          (pc_target),
        .misalign_err       (misalign_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_check++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write-back strobe and every redirect must match the head of its queue.
    always @(negedge clk) begin
        if (wb_en === 1'b1) begin
            if (wb_q.size() == 0) begin
                check("wb_unexpected", {31'd0, wb_en}, 32'd0);
            end else begin
                wb_exp_t e;
                e = wb_q.pop_front();
                check("wb_data", wb_data, e.data);
                check("wb_reg", {27'd0, wb_reg}, {27'd0, e.rd});
                check("wb_cycle", cyc, e.due);
                check("wb_stall_out", {31'd0, stall_flag_mem_out}, 32'd0);
            end
        end
        if (pc_src === 1'b1) begin
            if (pc_q.size() == 0) begin
                check("pc_unexpected", {31'd0, pc_src}, 32'd0);
            end else begin
                pc_exp_t p;
                p = pc_q.pop_front();
                check("pc_target", pc_target, p.target);
                check("pc_cycle", cyc, p.due);
            end
        end
    end

    task automatic idle_inputs();
        stall_flag_mem_in = 1'b1;
        alu_result        = '0;
        store_data        = '0;
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        reg_write_in      = 1'b0;
        dest_reg          = '0;
        branch_in         = 1'b0;
        zero_in           = 1'b0;
        branch_target     = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (hold_upstream && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_wait_timeout", {31'd0, hold_upstream}, 32'd0);
    endtask

    // Issues one instruction; exp_load is the hand-computed RAM word for an aligned load.
    task automatic issue(input logic [31:0] addr, input logic [31:0] sdata,
                         input logic rd, input logic wr, input logic regw,
                         input logic [4:0] dst, input logic br, input logic z,
                         input logic [31:0] tgt, input logic [31:0] exp_load);
        wb_exp_t e;
        pc_exp_t p;
        int      acc;
        wait_idle();
        stall_flag_mem_in = 1'b0;
        alu_result        = addr;
        store_data        = sdata;
        mem_read          = rd;
        mem_write         = wr;
        reg_write_in      = regw;
        dest_reg          = dst;
        branch_in         = br;
        zero_in           = z;
        branch_target     = tgt;
        @(posedge clk);
        #1;
        acc = cyc;
        idle_inputs();
        if (!(rd || wr) && regw) begin
            e.data = addr; e.rd = dst; e.due = acc;
            wb_q.push_back(e);
        end
        if (rd && !wr && regw && addr[1:0] == 2'b00) begin
            e.data = exp_load; e.rd = dst; e.due = acc + LAT;
            wb_q.push_back(e);
        end
        if (br && z) begin
            p.target = tgt; p.due = acc;
            pc_q.push_back(p);
        end
    endtask

    initial begin
        int h;
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_reg", {27'd0, wb_reg}, 32'd0);
        check("rst_wb_en", {31'd0, wb_en}, 32'd0);
        check("rst_stall_out", {31'd0, stall_flag_mem_out}, 32'd1);
        check("rst_pc_src", {31'd0, pc_src}, 32'd0);
        check("rst_pc_target", pc_target, 32'd0);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);
        check("rst_hold", {31'd0, hold_upstream}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bubble_stall_out", {31'd0, stall_flag_mem_out}, 32'd1);
            check("bubble_wb_en", {31'd0, wb_en}, 32'd0);
            check("bubble_pc_src", {31'd0, pc_src}, 32'd0);
        end

        // ALU op: result appears right after the accept edge, no back-pressure.
        issue(32'h0000_002A, 32'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 32'd0, 32'd0);
        check("alu_hold", {31'd0, hold_upstream}, 32'd0);
        check("alu_stall_out", {31'd0, stall_flag_mem_out}, 32'd0);
        @(posedge clk);
        #1;
        check("alu_hold_next", {31'd0, hold_upstream}, 32'd0);

        // Store: hold_upstream must be high for exactly LAT cycles.
        issue(32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 32'd0, 32'd0);
        h = 0;
        while (hold_upstream && h < 20) begin
            h++;
            @(posedge clk);
            #1;
        end
        check("store_hold_cycles", h, LAT);
        check("store_done_stall_out", {31'd0, stall_flag_mem_out}, 32'd0);
        check("store_done_wb_en", {31'd0, wb_en}, 32'd0);

        issue(32'h0000_0010, 32'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 32'd0, 32'hDEAD_BEEF);

        // Word index 64 wraps to index 0.
        issue(32'h0000_0100, 32'h0000_1234, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        issue(32'h0000_0000, 32'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 32'd0, 32'h0000_1234);

        issue(32'h0000_0012, 32'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 32'd0, 32'd0);
        check("mis_hold", {31'd0, hold_upstream}, 32'd0);
        check("mis_stall_out", {31'd0, stall_flag_mem_out}, 32'd0);
        check("mis_wb_en", {31'd0, wb_en}, 32'd0);
        check("mis_err", {31'd0, misalign_err}, 32'd1);

        issue(32'h0000_0000, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 32'h0000_0040, 32'd0);
        issue(32'h0000_0000, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h0000_0040, 32'd0);
        // Branch resolved at accept even alongside a load.
        issue(32'h0000_0000, 32'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_1234);
        wait_idle();
        check("mis_err_sticky", {31'd0, misalign_err}, 32'd1);

        issue(32'h0000_0008, 32'hA5A5_0008, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        issue(32'h0000_0008, 32'h0000_0055, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("abort_busy", {31'd0, hold_upstream}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_hold", {31'd0, hold_upstream}, 32'd0);
        check("abort_stall_out", {31'd0, stall_flag_mem_out}, 32'd1);
        check("abort_wb_data", wb_data, 32'd0);
        check("abort_wb_reg", {27'd0, wb_reg}, 32'd0);
        check("abort_misalign", {31'd0, misalign_err}, 32'd0);
        check("abort_pc_target", pc_target, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        issue(32'h0000_0008, 32'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 32'd0, 32'hA5A5_0008);

        wait_idle();
        repeat (4) @(posedge clk);
        #1;
        check("wb_queue_drained", wb_q.size(), 32'd0);
        check("pc_queue_drained", pc_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline. It sits directly downstream of the execute stage and consumes its ALU result, zero flag, branch target and stall flag. It performs word loads and stores against a private data RAM with configurable access latency, resolves taken branches into a PC redirect, and presents register write-back data. While a memory access is in flight it back-pressures the upstream stages.

## Interface
- DATA_W, 32: datapath width.
- DEPTH, 64: data RAM depth in words; power of two.
- MEM_LATENCY, 2: RAM access latency in cycles; legal values 1–8.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- stall_flag_mem_in  in  1  1 = bubble from execute; all other inputs ignored.
- alu_result  in  DATA_W  ALU output; byte address for memory ops.
- store_data  in  DATA_W  rt value to store.
- mem_read  in  1  load.
- mem_write  in  1  store.
- reg_write_in  in  1  instruction writes a register.
- dest_reg  in  5  destination register number.
- branch_in  in  1  instruction is a branch.
- zero_in  in  1  ALU equality flag.
- branch_target  in  DATA_W  computed branch address.
- hold_upstream  out  1  1 = execute and earlier stages must freeze their inputs.
- wb_data  out  DATA_W  write-back value.
- wb_reg  out  5  write-back register number.
- wb_en  out  1  one-cycle write-back strobe.
- stall_flag_mem_out  out  1  1 = no instruction completed this cycle.
- pc_src  out  1  one-cycle taken-branch pulse.
- pc_target  out  DATA_W  redirect address; valid only when pc_src = 1.
- misalign_err  out  1  sticky flag: a misaligned memory op was seen.

## Operation
- FSM states: IDLE, BUSY.
- In IDLE, an instruction is accepted at a clock edge when stall_flag_mem_in = 0.
- Non-memory op, accepted at edge N:
  - At edge N: wb_data = alu_result, wb_reg = dest_reg, wb_en = reg_write_in, stall_flag_mem_out = 0.
- Memory op, accepted at edge N:
  - At edge N: latch address index, store_data, dest_reg, op type and reg_write_in; enter BUSY with cnt = MEM_LATENCY.
  - RAM index = alu_result[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- BUSY:
  - cnt decrements every edge.
  - At the edge where cnt = 1: perform the RAM access, pulse completion, return to IDLE.
  - Load completion: wb_data = RAM word, wb_en = latched reg_write_in.
  - Store completion: RAM word ← latched store_data, wb_en = 0.
- mem_read and mem_write both asserted: treated as a store.
- Misaligned memory op (alu_result[1:0] ≠ 0): no RAM access; completes at the accept edge as a non-memory op with wb_en = 0; misalign_err is set.
- Branch: at the accept edge, pc_src = branch_in & zero_in and pc_target = branch_target. Resolved regardless of any simultaneous memory op.
- hold_upstream = (state == BUSY), combinational.
- Inputs arriving while in BUSY are not sampled.

## Timing
- Reset values: state IDLE, cnt 0, wb_data 0, wb_reg 0, wb_en 0, stall_flag_mem_out 1, pc_src 0, pc_target 0, misalign_err 0.
- RAM contents are not cleared by reset.
- Non-memory latency: outputs valid in the cycle after the accept edge.
- Memory latency: result valid after edge N + MEM_LATENCY. hold_upstream is high for exactly MEM_LATENCY cycles.
- wb_en and pc_src are single-cycle pulses.
- stall_flag_mem_out is registered: it is 1 in every cycle with no completion, including every BUSY cycle except the completion edge.
- Reset asserted mid-BUSY: the access is aborted, no RAM write occurs, and all outputs take their reset values immediately.
- Back-to-back memory ops: the next op is accepted on the first edge after hold_upstream falls, giving one op per MEM_LATENCY+1 cycles.

## Structure
- Shared package mem_pkg holds:
  - the state enum {IDLE, BUSY};
  - the op-type constants OP_NONE, OP_LOAD, OP_STORE;
  - the MEM_LATENCY default;
  - the log2 helper for the index width.
- Sub-module mem_data_ram: single-port synchronous RAM, DEPTH × DATA_W, with write enable and a registered read.
- The FSM, counter, branch logic and output registers live in mem_stage.

## Test plan
- Reset, then hold stall_flag_mem_in = 1 for 5 cycles → stall_flag_mem_out = 1, wb_en = 0, pc_src = 0 throughout.
- Non-memory op: alu_result 0x0000_002A, dest_reg 3, reg_write_in 1 → next cycle wb_data 0x2A, wb_reg 3, wb_en 1 for one cycle; hold_upstream never asserts.
- With MEM_LATENCY 2:
  - Store 0xDEAD_BEEF to address 0x10 → hold_upstream high 2 cycles, wb_en 0.
  - Then load from 0x10 with dest_reg 7 → wb_data 0xDEAD_BEEF, wb_reg 7, wb_en 1 after accept edge + 2.
- Address wrap: store 0x1234 to 0x100 with DEPTH 64, then load from 0x0 → 0x1234. Load from 0x12 → no access, wb_en 0, misalign_err 1 and sticky until reset.
- Branch: branch_in 1, zero_in 1, branch_target 0x40 → pc_src pulses once with pc_target 0x40. Same inputs with zero_in 0 → pc_src stays 0.
- Reset mid-BUSY during a store of 0x55 to 0x8 → outputs return to reset values immediately; a subsequent load from 0x8 returns the prior contents, not 0x55.
